// File: rtl/regfile_write_scheduler.sv
// Write-port sequencer/arbiter for the 32x64 LEGv8 register file: optional zeroing sweep,
// then round-robin between ALU (req0) and load (req1) writeback. Option macro: REGFILE_CLEAR_EN.
module regfile_write_scheduler #(
    parameter int WIDTH = 64,
    parameter int AW    = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [AW-1:0]    req0_addr,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [AW-1:0]    req1_addr,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic [AW-1:0]    DA,
    output logic [WIDTH-1:0] D,
    output logic             W,
    output logic             wr_src,
    output logic             init_done
);

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

`ifdef REGFILE_CLEAR_EN
    localparam state_t RESET_STATE = ST_CLEAR;
    localparam logic   RESET_DONE  = 1'b0;
    logic [AW-1:0] clr_cnt, clr_cnt_nxt;
`else
    localparam state_t RESET_STATE = ST_RUN;
    localparam logic   RESET_DONE  = 1'b1;
`endif

    // Address 2**AW-1 is XZR: handshaken normally but never written.
    localparam logic [AW-1:0] XZR_ADDR = '1;

    state_t           state, state_nxt;
    logic             prio, prio_nxt;
    logic [AW-1:0]    da_nxt;
    logic [WIDTH-1:0] d_nxt;
    logic             w_nxt, src_nxt, done_nxt;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        prio_nxt   = prio;
        da_nxt     = DA;
        d_nxt      = D;
        w_nxt      = 1'b0;
        src_nxt    = wr_src;
        done_nxt   = init_done;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
`ifdef REGFILE_CLEAR_EN
        clr_cnt_nxt = clr_cnt;
`endif
        case (state)
            ST_RUN: begin
                // prio names the requester that wins when both are valid.
                req0_ready = req0_valid && (!req1_valid || !prio);
                req1_ready = req1_valid && (!req0_valid ||  prio);
                if (req0_ready) begin
                    da_nxt   = req0_addr;
                    d_nxt    = req0_data;
                    w_nxt    = (req0_addr != XZR_ADDR);
                    src_nxt  = 1'b0;
                    prio_nxt = 1'b1;
                end else if (req1_ready) begin
                    da_nxt   = req1_addr;
                    d_nxt    = req1_data;
                    w_nxt    = (req1_addr != XZR_ADDR);
                    src_nxt  = 1'b1;
                    prio_nxt = 1'b0;
                end
            end
            default: begin
`ifdef REGFILE_CLEAR_EN
                w_nxt       = 1'b1;
                da_nxt      = clr_cnt;
                d_nxt       = '0;
                clr_cnt_nxt = clr_cnt + AW'(1);
                if (clr_cnt == XZR_ADDR) begin
                    state_nxt = ST_RUN;
                    done_nxt  = 1'b1;
                end
`else
                state_nxt = ST_RUN;
                done_nxt  = 1'b1;
`endif
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= RESET_STATE;
            prio      <= 1'b0;
            DA        <= '0;
            D         <= '0;
            W         <= 1'b0;
            wr_src    <= 1'b0;
            init_done <= RESET_DONE;
`ifdef REGFILE_CLEAR_EN
            clr_cnt   <= '0;
`endif
        end else begin
            state     <= state_nxt;
            prio      <= prio_nxt;
            DA        <= da_nxt;
            D         <= d_nxt;
            W         <= w_nxt;
            wr_src    <= src_nxt;
            init_done <= done_nxt;
`ifdef REGFILE_CLEAR_EN
            clr_cnt   <= clr_cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler; covers both REGFILE_CLEAR_EN builds.
module tb_regfile_write_scheduler;

    localparam int WIDTH = 64;
    localparam int AW    = 5;
`ifdef REGFILE_CLEAR_EN
    localparam logic DONE_AT_RESET = 1'b0;
`else
    localparam logic DONE_AT_RESET = 1'b1;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic [AW-1:0]    req0_addr = '0, req1_addr = '0;
    logic [WIDTH-1:0] req0_data = '0, req1_data = '0;
    logic             req0_ready, req1_ready;
    logic [AW-1:0]    DA;
    logic [WIDTH-1:0] D;
    logic             W, wr_src, init_done;

    int checks   = 0;
    int failures = 0;

    regfile_write_scheduler #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .DA         (DA),
        .D          (D),
        .W          (W),
        .wr_src     (wr_src),
        .init_done  (init_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic             v0;
        logic [AW-1:0]    a0;
        logic [WIDTH-1:0] d0;
        logic             v1;
        logic [AW-1:0]    a1;
        logic [WIDTH-1:0] d1;
        logic             rdy0;
        logic             rdy1;
        logic             w;
        logic [AW-1:0]    da;
        logic [WIDTH-1:0] d;
        logic             src;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

`ifdef REGFILE_CLEAR_EN
    // Entered at a negedge just after reset release; checks edges 1..n of the sweep.
    task automatic clear_edges(input int n);
        for (int k = 1; k <= n; k++) begin
            @(posedge clock);
            #1;
            check($sformatf("clr_w_%0d", k), 64'(W), 64'd1);
            check($sformatf("clr_da_%0d", k), 64'(DA), 64'(k - 1));
            check($sformatf("clr_d_%0d", k), D, 64'd0);
            check($sformatf("clr_done_%0d", k), 64'(init_done), 64'(k == 32));
            check($sformatf("clr_rdy_%0d", k), {62'd0, req0_ready, req1_ready}, 64'd0);
        end
    endtask
`endif

    initial begin
        // v0 v0addr v0data v1 v1addr v1data | rdy0 rdy1 W DA D src
        vecs[0]  = '{1'b1, 5'd7,  64'h77,               1'b0, 5'd0,  64'h0,     1'b1, 1'b0, 1'b1, 5'd7,  64'h77,               1'b0};
        vecs[1]  = '{1'b0, 5'd0,  64'h0,                1'b0, 5'd0,  64'h0,     1'b0, 1'b0, 1'b0, 5'd7,  64'h77,               1'b0};
        vecs[2]  = '{1'b1, 5'd5,  64'h0123456789ABCDEF, 1'b0, 5'd0,  64'h0,     1'b1, 1'b0, 1'b1, 5'd5,  64'h0123456789ABCDEF, 1'b0};
        vecs[3]  = '{1'b0, 5'd0,  64'h0,                1'b1, 5'd31, 64'hFFFF,  1'b0, 1'b1, 1'b0, 5'd31, 64'hFFFF,             1'b1};
        vecs[4]  = '{1'b1, 5'd2,  64'h22,               1'b0, 5'd0,  64'h0,     1'b1, 1'b0, 1'b1, 5'd2,  64'h22,               1'b0};
        vecs[5]  = '{1'b0, 5'd0,  64'h0,                1'b1, 5'd9,  64'h99,    1'b0, 1'b1, 1'b1, 5'd9,  64'h99,               1'b1};
        vecs[6]  = '{1'b1, 5'd1,  64'h101,              1'b1, 5'd11, 64'h111,   1'b1, 1'b0, 1'b1, 5'd1,  64'h101,              1'b0};
        vecs[7]  = '{1'b1, 5'd2,  64'h102,              1'b1, 5'd11, 64'h111,   1'b0, 1'b1, 1'b1, 5'd11, 64'h111,              1'b1};
        vecs[8]  = '{1'b1, 5'd2,  64'h102,              1'b1, 5'd12, 64'h112,   1'b1, 1'b0, 1'b1, 5'd2,  64'h102,              1'b0};
        vecs[9]  = '{1'b1, 5'd3,  64'h103,              1'b1, 5'd12, 64'h112,   1'b0, 1'b1, 1'b1, 5'd12, 64'h112,              1'b1};
        vecs[10] = '{1'b1, 5'd31, 64'hAA,               1'b1, 5'd13, 64'h113,   1'b1, 1'b0, 1'b0, 5'd31, 64'hAA,               1'b0};
        vecs[11] = '{1'b0, 5'd0,  64'h0,                1'b1, 5'd13, 64'h113,   1'b0, 1'b1, 1'b1, 5'd13, 64'h113,              1'b1};
        vecs[12] = '{1'b0, 5'd0,  64'h0,                1'b0, 5'd0,  64'h0,     1'b0, 1'b0, 1'b0, 5'd13, 64'h113,              1'b1};

        repeat (2) @(posedge clock);
        #1;
        check("rst_w", 64'(W), 64'd0);
        check("rst_da", 64'(DA), 64'd0);
        check("rst_d", D, 64'd0);
        check("rst_src", 64'(wr_src), 64'd0);
        check("rst_done", 64'(init_done), 64'(DONE_AT_RESET));
        check("rst_rdy", {62'd0, req0_ready, req1_ready}, 64'd0);

        @(negedge clock);
        reset = 1'b1;
`ifdef REGFILE_CLEAR_EN
        clear_edges(10);
        #1;
        reset = 1'b0;
        #1;
        check("midclr_w", 64'(W), 64'd0);
        check("midclr_da", 64'(DA), 64'd0);
        check("midclr_done", 64'(init_done), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        clear_edges(32);
        @(posedge clock);
        #1;
        check("clr_edge33_w", 64'(W), 64'd0);
        check("clr_edge33_done", 64'(init_done), 64'd1);
        @(negedge clock);
`endif

        // Each vector: drive at a negedge, check readies, then the registered result after the edge.
        for (int i = 0; i < 13; i++) begin
            req0_valid = vecs[i].v0;
            req0_addr  = vecs[i].a0;
            req0_data  = vecs[i].d0;
            req1_valid = vecs[i].v1;
            req1_addr  = vecs[i].a1;
            req1_data  = vecs[i].d1;
            #1;
            check($sformatf("v%0d_rdy0", i), 64'(req0_ready), 64'(vecs[i].rdy0));
            check($sformatf("v%0d_rdy1", i), 64'(req1_ready), 64'(vecs[i].rdy1));
            @(posedge clock);
            #1;
            check($sformatf("v%0d_w", i), 64'(W), 64'(vecs[i].w));
            check($sformatf("v%0d_da", i), 64'(DA), 64'(vecs[i].da));
            check($sformatf("v%0d_d", i), D, vecs[i].d);
            check($sformatf("v%0d_src", i), 64'(wr_src), 64'(vecs[i].src));
            check($sformatf("v%0d_done", i), 64'(init_done), 64'd1);
            @(negedge clock);
        end

        // Reset right after an accepted write; prio must also return to 0.
        req0_valid = 1'b1;
        req0_addr  = 5'd4;
        req0_data  = 64'h44;
        @(posedge clock);
        #1;
        check("pre_rst_w", 64'(W), 64'd1);
        check("pre_rst_da", 64'(DA), 64'd4);
        idle_inputs();
        #1;
        reset = 1'b0;
        #1;
        check("run_rst_w", 64'(W), 64'd0);
        check("run_rst_da", 64'(DA), 64'd0);
        check("run_rst_d", D, 64'd0);
        check("run_rst_done", 64'(init_done), 64'(DONE_AT_RESET));
        @(negedge clock);
        reset = 1'b1;
        req0_valid = 1'b1;
        req0_addr  = 5'd8;
        req0_data  = 64'h88;
        req1_valid = 1'b1;
        req1_addr  = 5'd9;
        req1_data  = 64'h99;
        #1;
`ifdef REGFILE_CLEAR_EN
        check("post_rst_rdy", {62'd0, req0_ready, req1_ready}, 64'd0);
        @(posedge clock);
        #1;
        check("post_rst_w", 64'(W), 64'd1);
        check("post_rst_da", 64'(DA), 64'd0);
        check("post_rst_d", D, 64'd0);
`else
        check("post_rst_rdy", {62'd0, req0_ready, req1_ready}, 64'd2);
        @(posedge clock);
        #1;
        check("post_rst_w", 64'(W), 64'd1);
        check("post_rst_da", 64'(DA), 64'd8);
        check("post_rst_d", D, 64'h88);
        check("post_rst_src", 64'(wr_src), 64'd0);
`endif
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_write_scheduler.md
# regfile_write_scheduler

Sequencer and arbiter for the single write port (DA, D, W) of the 32x64 LEGv8 register file. After reset it optionally walks all 32 registers writing zero, then arbitrates between two writeback requesters (req0 = ALU writeback, req1 = memory-load writeback). Arbitration is round-robin with a valid/ready handshake. It drives the register file write port from registers, and drops writes to X31 (XZR). It sits between the execute/memory writeback stages and the register file.

## Interface

Parameters:
- WIDTH, 64, data width of the register file.
- AW, 5, register address width; 2**AW registers.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; 0 forces the reset state immediately.
- req0_valid  input  1  requester 0 has a write pending.
- req0_addr  input  AW  requester 0 destination register.
- req0_data  input  WIDTH  requester 0 write data.
- req0_ready  output  1  requester 0 write accepted this cycle when valid is also high.
- req1_valid, req1_addr, req1_data, req1_ready: same as req0_* for requester 1.
- DA  output  AW  register file write address; registered.
- D  output  WIDTH  register file write data; registered.
- W  output  1  register file write enable; registered.
- wr_src  output  1  requester whose write is on DA/D/W this cycle; registered.
- init_done  output  1  high once the scheduler is in RUN; registered.

## Operation

- FSM states: CLEAR, RUN. Reset enters CLEAR (see Configuration).
- CLEAR:
  - 5-bit counter clr_cnt starts at 0.
  - Each cycle, register W=1, DA=clr_cnt, D=0, then increment clr_cnt.
  - After the cycle that writes DA=31, go to RUN and set init_done=1.
  - req0_ready and req1_ready are 0 throughout CLEAR.
- RUN, ready logic (combinational from the valids and the prio register):
  - Only req0_valid high: req0_ready=1.
  - Only req1_valid high: req1_ready=1.
  - Both high: only the requester selected by prio gets ready=1.
  - Neither high: both readies are 0.
  - Never both readies high at once.
- RUN, accept (valid && ready on requester i): next edge registers DA=req_i_addr, D=req_i_data, wr_src=i. W=1 unless req_i_addr==31.
- XZR rule: a write to address 31 is still handshaken (ready=1, counts as accepted) but produces W=0. DA and D still update.
- No accept in a cycle: next edge W=0; DA, D and wr_src hold.
- Round-robin: prio resets to 0. On any accept from requester i, prio <= ~i. Single-requester traffic also updates prio.
- Requesters must hold addr and data stable while valid is high and ready is low.
- Reset mid-operation: immediately W=0, state CLEAR, clr_cnt=0, any in-flight write lost. The clear sequence restarts from register 0 after reset deasserts.

## Timing

- Reset values: DA=0, D=0, W=0, wr_src=0, init_done=0, prio=0, clr_cnt=0, both readies 0.
- CLEAR: edge k (k=1..32) after reset release drives DA=k-1, W=1, D=0. init_done rises at edge 32.
- Readies become valid combinationally in the cycle after edge 32. First possible accept is at edge 33.
- Latency: one cycle from accept edge to DA/D/W valid. The register file writes on the following edge.
- Throughput: one write per cycle sustained. Under contention with both valid continuously, grants alternate 0,1,0,1.

## Configuration

- REGFILE_CLEAR_EN defined: CLEAR state and clr_cnt are compiled in and behave as above.
- REGFILE_CLEAR_EN undefined:
  - Reset enters RUN directly, with init_done=1 as its reset value.
  - No zeroing writes are issued; the register file relies on its own reset.
  - First accept is possible at the first edge after reset release.

## Test plan

- Clear sweep (macro defined): release reset, both valids low -> edges 1..32 show W=1, DA=0..31, D=0. init_done=1 at edge 32, W=0 at edge 33.
- Single requester: in RUN, req0 writes addr 5, data 64'h0123456789ABCDEF -> req0_ready=1 that cycle. Next edge: DA=5, D=64'h0123456789ABCDEF, W=1, wr_src=0.
- Contention: both valid for 4 cycles, req0 addr 1..4, req1 addr 11..14 -> writes in order 1,11,2,12 with wr_src 0,1,0,1. Readies never both high.
- XZR: req1 writes addr 31, data 64'hFFFF -> req1_ready=1 and next edge W=0. A following req0 write to addr 2 gets W=1.
- Reset mid-clear: assert reset at edge 10 -> W=0 immediately. After release, DA restarts at 0 and init_done rises 32 edges later.
- Macro undefined: init_done=1 out of reset. A req0 write to addr 7 in the first cycle after release appears on DA=7, W=1 at the next edge.
